instr_fetch_queue: RTL and testbench

Decoupling queue between the instruction-fetch stage (PC register plus instruction memory) and the register-fetch/decode stage of the pipelined LEGv8 core. Each entry holds one fetched {pc, instr} pair. Entries are produced on a valid/ready handshake and consumed by decode on a second valid/ready handshake. A taken branch drops all queued, wrong-path instructions in one cycle through the flush input.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/instr_queue_mem.sv | 34 +++
 rtl/instr_fetch_queue.sv | 98 +++++++++
 tb/tb_instr_fetch_queue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// Module      : fetch_pkg
// Description : Shared widths, entry type and gating constant for the
//               instruction-fetch queue.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int PC_WIDTH    = 64;
  localparam int INSTR_WIDTH = 32;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0;

endpackage

`default_nettype wire

// File: rtl/instr_queue_mem.sv
//------------------------------------------------------------------------------
// Module      : instr_queue_mem
// Description : DEPTH-entry register array, one synchronous write port and
//               one combinational read port. Contents are never reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  fetch_entry_t             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output fetch_entry_t             rd_data
);

  fetch_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
//------------------------------------------------------------------------------
// Module      : instr_fetch_queue
// Description : Circular decoupling queue of {pc, instr} pairs between fetch
//               and decode, with single-cycle flush on a taken branch.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_queue
  import fetch_pkg::fetch_entry_t;
  import fetch_pkg::NOP_INSTR;
#(
  parameter int DEPTH       = 4,
  parameter int PC_WIDTH    = fetch_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = fetch_pkg::INSTR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [PC_WIDTH-1:0]      in_pc,
  input  logic [INSTR_WIDTH-1:0]   in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_WIDTH-1:0]      out_pc,
  output logic [INSTR_WIDTH-1:0]   out_instr,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic         w_push;
  logic         w_pop;
  fetch_entry_t w_wr_data;
  fetch_entry_t w_rd_data;

  // Full refuses a push even if decode pops the same cycle.
  assign in_ready  = (r_count != c_full);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  assign w_wr_data.pc    = in_pc;
  assign w_wr_data.instr = in_instr;

  instr_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_push),
    .wr_addr (r_wr_ptr),
    .wr_data (w_wr_data),
    .rd_addr (r_rd_ptr),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Stale storage is hidden whenever the queue is empty.
  assign out_pc    = out_valid ? w_rd_data.pc    : '0;
  assign out_instr = out_valid ? w_rd_data.instr : NOP_INSTR;
  assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
//------------------------------------------------------------------------------
// Module      : tb_instr_fetch_queue
// Description : Self-checking bench for instr_fetch_queue against a queue model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        flush;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  logic [95:0] model_q[$];

  instr_fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(64), .INSTR_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance one edge, update the model, then idle.
  task automatic cycle(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    logic push, pop;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    push = v && (model_q.size() < DEPTH) && !fl;
    pop  = rdy && (model_q.size() > 0) && !fl;
    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back({pc, ins});
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    model_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr got=%h want=0", out_instr); end
    cycle(1'b1, 64'd0, 32'hF84003E9, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_out_valid got=%b want=1", out_valid); end
    total++; if (out_pc !== 64'd0) begin bad++; $display("FAIL first_out_pc got=%0d want=0", out_pc); end
    total++; if (out_instr !== 32'hF84003E9) begin bad++; $display("FAIL first_out_instr got=%h want=f84003e9", out_instr); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL first_count got=%0d want=1", count); end
    cycle(1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_fill;
    for (int i = 0; i < 4; i++) cycle(1'b1, 64'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0);
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b want=0", in_ready); end
    // Full queue refuses a push even with a concurrent pop.
    cycle(1'b1, 64'd16, 32'hDEAD, 1'b1, 1'b0);
    total++; if (count !== 3'd3) begin bad++; $display("FAIL full_pushpop_count got=%0d want=3", count); end
    total++; if (out_pc !== 64'd4) begin bad++; $display("FAIL full_pushpop_head got=%0d want=4", out_pc); end
    for (int i = 1; i < 4; i++) begin
      total++; if (out_pc !== 64'(4 * i)) begin bad++; $display("FAIL fill_pop_pc got=%0d want=%0d", out_pc, 4 * i); end
      cycle(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drained_out_valid got=%b want=0", out_valid); end
    total++; if (out_pc !== 64'd0) begin bad++; $display("FAIL drained_out_pc got=%0d want=0", out_pc); end
  endtask

  task automatic test_push_pop;
    cycle(1'b1, 64'd0, 32'hA0, 1'b0, 1'b0);
    cycle(1'b1, 64'd4, 32'hA4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++; if (out_pc !== 64'(4 * i)) begin bad++; $display("FAIL pushpop_pc got=%0d want=%0d", out_pc, 4 * i); end
      cycle(1'b1, 64'(8 + 4 * i), 32'hA8 + 32'(4 * i), 1'b1, 1'b0);
      total++; if (count !== 3'd2) begin bad++; $display("FAIL pushpop_count got=%0d want=2", count); end
    end
    cycle(1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap;
    int next_push = 0;
    int next_pop  = 0;
    cycle(1'b1, 64'd0, 32'hB0, 1'b0, 1'b0);
    cycle(1'b1, 64'd4, 32'hB4, 1'b0, 1'b0);
    next_push = 2;
    while (next_pop < 10) begin
      total++; if (out_pc !== 64'(4 * next_pop)) begin bad++; $display("FAIL wrap_pc got=%0d want=%0d", out_pc, 4 * next_pop); end
      cycle(next_push < 10, 64'(4 * next_push), 32'hB0 + 32'(4 * next_push), 1'b1, 1'b0);
      if (next_push < 10) next_push++;
      next_pop++;
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'(200 + 4 * i), 32'hC0 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 64'd100, 32'hC100, 1'b1, 1'b1);
    total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    total++; if (out_pc !== 64'd0) begin bad++; $display("FAIL flush_out_pc got=%0d want=0", out_pc); end
    cycle(1'b1, 64'd24, 32'hC024, 1'b0, 1'b0);
    total++; if (out_pc !== 64'd24) begin bad++; $display("FAIL flush_next_pc got=%0d want=24", out_pc); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL flush_next_count got=%0d want=1", count); end
    cycle(1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'(300 + 4 * i), 32'hD0 + 32'(i), 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    model_q.delete();
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL midreset_count got=%0d want=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_in_ready got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1'b1, 64'd40, 32'hD040, 1'b0, 1'b0);
    total++; if (out_pc !== 64'd40) begin bad++; $display("FAIL midreset_head got=%0d want=40", out_pc); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL midreset_head_count got=%0d want=1", count); end
    cycle(1'b0, 64'd0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    logic [63:0] exp_pc;
    logic [31:0] exp_in;
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      exp_pc = (model_q.size() != 0) ? model_q[0][95:32] : 64'd0;
      exp_in = (model_q.size() != 0) ? model_q[0][31:0]  : 32'd0;
      total++; if (count !== 3'(model_q.size())) begin bad++; $display("FAIL rand_count n=%0d got=%0d want=%0d", n, count, model_q.size()); end
      total++; if (in_ready !== (model_q.size() != DEPTH)) begin bad++; $display("FAIL rand_in_ready n=%0d got=%b", n, in_ready); end
      total++; if (out_valid !== (model_q.size() != 0)) begin bad++; $display("FAIL rand_out_valid n=%0d got=%b", n, out_valid); end
      total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL rand_out_pc n=%0d got=%h want=%h", n, out_pc, exp_pc); end
      total++; if (out_instr !== exp_in) begin bad++; $display("FAIL rand_out_instr n=%0d got=%h want=%h", n, out_instr, exp_in); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1;
    test_reset;
    test_fill;
    test_push_pop;
    test_wrap;
    test_flush;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
